// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/MEM memory bus arbiter.
// Holds the FSM state codes, the grant codes and the arbitration pick.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ADDR  = 3'd1,
    ARB_WAIT  = 3'd2,
    ARB_RESP  = 3'd3,
    ARB_DRAIN = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  // Under contention round-robin picks the side that did not win last.
  function automatic gnt_e arb_pick(
    input logic inst_req,
    input logic data_req,
    input logic rr_en,
    input gnt_e rr_last
  );
    if (inst_req && data_req) begin
      if (rr_en)
        return (rr_last == GNT_INST) ? GNT_DATA : GNT_INST;
      return GNT_DATA;
    end
    return data_req ? GNT_DATA : GNT_INST;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports plus the shared SRAM-like bus.
// slave: arbiter view; master: pipeline and memory view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ok;
  logic          inst_err;

  logic            data_req;
  logic            data_wr;
  logic [DW/8-1:0] data_wstrb;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic [DW-1:0]   data_rdata;
  logic            data_ok;
  logic            data_err;

  logic            bus_req;
  logic            bus_wr;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_addr_ok;
  logic            bus_data_ok;
  logic [DW-1:0]   bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_ok, inst_err,
    input  data_req, data_wr, data_wstrb,
    input  data_addr, data_wdata,
    output data_rdata, data_ok, data_err,
    output bus_req, bus_wr, bus_wstrb,
    output bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_ok, inst_err,
    output data_req, data_wr, data_wstrb,
    output data_addr, data_wdata,
    input  data_rdata, data_ok, data_err,
    input  bus_req, bus_wr, bus_wstrb,
    input  bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/bus_watchdog.sv
// Per-transfer cycle counter for the bus arbiter.
// expired flags the last allowed ADDR/WAIT cycle.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and MEM-stage load/store.
// MEM_ARB_RR_EN selects round-robin instead of data-first priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             resetn,
  mem_bus_arbiter_if.slave io
);

  arb_state_e state_q, state_d;
  gnt_e       gnt_q, gnt_d;
  gnt_e       win;

  logic            bus_req_q, bus_req_d;
  logic            bus_wr_q, bus_wr_d;
  logic [DW/8-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;

  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic          inst_ok_q, inst_ok_d;
  logic          inst_err_q, inst_err_d;
  logic          data_ok_q, data_ok_d;
  logic          data_err_q, data_err_d;

  logic          ok_set, err_set;
  logic [DW-1:0] rd_set;
  logic          wd_clr, wd_en, wd_exp;

`ifdef MEM_ARB_RR_EN
  gnt_e rr_last_q, rr_last_d;

  always_comb win = arb_pick(io.inst_req, io.data_req, 1'b1, rr_last_q);
`else
  always_comb win = arb_pick(io.inst_req, io.data_req, 1'b0, GNT_INST);
`endif

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    bus_req_d   = 1'b0;
    bus_wr_d    = bus_wr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ok_set      = 1'b0;
    err_set     = 1'b0;
    rd_set      = '0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (io.inst_req || io.data_req) begin
          state_d   = ARB_ADDR;
          gnt_d     = win;
          bus_req_d = 1'b1;
          wd_clr    = 1'b1;
`ifdef MEM_ARB_RR_EN
          rr_last_d = win;
`endif
          if (win == GNT_DATA) begin
            bus_wr_d    = io.data_wr;
            bus_wstrb_d = io.data_wstrb;
            bus_addr_d  = io.data_addr;
            bus_wdata_d = io.data_wdata;
          end else begin
            bus_wr_d    = 1'b0;
            bus_wstrb_d = '0;
            bus_addr_d  = io.inst_addr;
            bus_wdata_d = '0;
          end
        end
      end
      ARB_ADDR: begin
        wd_en = 1'b1;
        if (io.bus_addr_ok && io.bus_data_ok) begin
          state_d = ARB_RESP;
          ok_set  = 1'b1;
          rd_set  = bus_wr_q ? '0 : io.bus_rdata;
        end else if (io.bus_addr_ok) begin
          state_d = ARB_WAIT;
        end else if (wd_exp) begin
          state_d = ARB_RESP;
          err_set = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      ARB_WAIT: begin
        wd_en = 1'b1;
        if (io.bus_data_ok) begin
          state_d = ARB_RESP;
          ok_set  = 1'b1;
          rd_set  = bus_wr_q ? '0 : io.bus_rdata;
        end else if (wd_exp) begin
          // Release the requester now; the bus still owes a data_ok.
          state_d = ARB_DRAIN;
          err_set = 1'b1;
        end
      end
      ARB_DRAIN: begin
        if (io.bus_data_ok)
          state_d = ARB_IDLE;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    inst_ok_d    = 1'b0;
    inst_err_d   = 1'b0;
    inst_rdata_d = '0;
    data_ok_d    = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = '0;
    if (gnt_q == GNT_DATA) begin
      data_ok_d    = ok_set;
      data_err_d   = err_set;
      data_rdata_d = rd_set;
    end else begin
      inst_ok_d    = ok_set;
      inst_err_d   = err_set;
      inst_rdata_d = rd_set;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= GNT_DATA;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      inst_err_q   <= 1'b0;
      data_rdata_q <= '0;
      data_ok_q    <= 1'b0;
      data_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= GNT_INST;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      inst_ok_q    <= inst_ok_d;
      inst_err_q   <= inst_err_d;
      data_rdata_q <= data_rdata_d;
      data_ok_q    <= data_ok_d;
      data_err_q   <= data_err_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign io.bus_req    = bus_req_q;
  assign io.bus_wr     = bus_wr_q;
  assign io.bus_wstrb  = bus_wstrb_q;
  assign io.bus_addr   = bus_addr_q;
  assign io.bus_wdata  = bus_wdata_q;
  assign io.inst_rdata = inst_rdata_q;
  assign io.inst_ok    = inst_ok_q;
  assign io.inst_err   = inst_err_q;
  assign io.data_rdata = data_rdata_q;
  assign io.data_ok    = data_ok_q;
  assign io.data_err   = data_err_q;

endmodule
